inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_i input 1 (rising edge), then rst_i input 1 (0 = reset, asynchronous).
REQ-002 The block SHALL have input pc_stop_i, 1 bit: hazard stall; hold the fetched instruction and do not advance.
REQ-003 The block SHALL have input jump_en_i, 1 bit: redirect request from execute.
REQ-004 The block SHALL have input jump_addr_i, 32 bits: redirect target.
REQ-005 The block SHALL have output ibus_req_o, 1 bit: instruction bus read request.
REQ-006 The block SHALL have output ibus_addr_o, 32 bits: instruction bus address.
REQ-007 The block SHALL have input ibus_ack_i, 1 bit: read data valid, and input ibus_rdata_i, 32 bits: instruction word.
REQ-008 The block SHALL have outputs inst_fo and pc_fo, 32 bits each: fetched instruction and its PC, driven toward the fetch/decode register.
REQ-009 The block SHALL have output fetch_valid_o, 1 bit: inst_fo and pc_fo hold a real instruction.
REQ-010 The block SHALL have output pipeline_flush_o, 1 bit: one-cycle flush pulse to the fetch/decode register.
REQ-011 The block SHALL have output misalign_o, 1 bit: misaligned redirect pulse, present only with the macro in REQ-028 defined.

Function
REQ-012 The block SHALL hold a 32-bit PC register; the reset vector is 0x0000_0000.
REQ-013 The FSM SHALL have states IDLE, REQ and HOLD; IDLE lasts exactly one cycle after reset release and then goes to REQ.
REQ-014 In REQ, the block SHALL drive ibus_req_o=1 and ibus_addr_o=PC, keeping both stable until ibus_ack_i; in IDLE and HOLD, ibus_req_o SHALL be 0.
REQ-015 In REQ, ack with no redirect pending or present SHALL register inst_fo<=ibus_rdata_i, pc_fo<=PC, fetch_valid_o<=1 and PC<=PC+4.
- Next state is HOLD if pc_stop_i=1 in the ack cycle, else REQ.
REQ-016 In REQ, a cycle with no ack SHALL set fetch_valid_o<=0.
REQ-017 In HOLD, inst_fo, pc_fo and fetch_valid_o SHALL stay unchanged while pc_stop_i=1; pc_stop_i=0 SHALL return the FSM to REQ on the next edge.
REQ-018 PC+4 SHALL wrap modulo 2^32: 0xFFFF_FFFC advances to 0x0000_0000.
REQ-019 jump_en_i=1 SHALL pulse pipeline_flush_o=1 in the next cycle and set fetch_valid_o<=0.
REQ-020 jump_en_i=1 in IDLE or HOLD, or in REQ together with ack, SHALL:
- load PC<=jump_addr_i with bits[1:0] forced to 0;
- enter REQ;
- discard the ack data.
REQ-021 jump_en_i=1 in REQ without ack SHALL record a pending redirect (target latched) and keep ibus_addr_o unchanged.
- The next ack SHALL be discarded, with PC<=target and the FSM staying in REQ.
REQ-022 A further jump_en_i while a redirect is pending SHALL overwrite the latched target; the latest target wins.
REQ-023 When jump_en_i and pc_stop_i are both 1, jump SHALL win; stall is ignored in that cycle.
REQ-024 pipeline_flush_o SHALL be 0 in every cycle except those defined by REQ-019.

Reset
REQ-025 While rst_i=0, the block SHALL immediately force:
- PC, inst_fo, pc_fo and ibus_addr_o to 0;
- ibus_req_o, fetch_valid_o, pipeline_flush_o, misalign_o and the pending flag to 0;
- the FSM to IDLE.
REQ-026 Reset asserted mid-transaction SHALL abandon the bus request; an ack arriving in IDLE SHALL be ignored.
REQ-027 After release, the first request SHALL appear in the second cycle, with ibus_addr_o=0x0000_0000.

Configuration
REQ-028 When FETCH_MISALIGN_CHK_EN is defined, a redirect with jump_addr_i[1:0]!=0 SHALL pulse misalign_o=1 for one cycle, aligned with pipeline_flush_o; the redirect still proceeds to the aligned address.
REQ-029 When FETCH_MISALIGN_CHK_EN is undefined, misalign_o SHALL be absent and no check logic SHALL exist.

Verification
REQ-030 The bench SHALL cover reset release with ack every cycle -> ibus_addr_o 0,4,8,C; pc_fo follows one cycle later; fetch_valid_o=1.
REQ-031 The bench SHALL cover pc_stop_i=1 in the ack cycle of PC 0x8, held 3 cycles -> inst_fo/pc_fo=0x8 held, ibus_req_o=0, next request to 0xC.
REQ-032 The bench SHALL cover jump_en_i with 0x100 while waiting for ack at 0x10 -> addr stays 0x10 until ack, data discarded, next request 0x100, flush pulse one cycle.
REQ-033 The bench SHALL cover two jumps (0x200 then 0x300) before a delayed ack -> next request 0x300.
REQ-034 The bench SHALL cover PC preloaded by a jump to 0xFFFF_FFFC, then ack -> next request 0x0000_0000.
REQ-035 The bench SHALL cover a jump to 0x102 with the macro defined -> misalign_o=1 for one cycle, next request 0x100; without the macro -> next request 0x100 and no misalign_o port.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: PC + IDLE/REQ/HOLD instruction-bus FSM; ack data lands on inst_fo/pc_fo one edge later, pc_stop_i holds it.
// Define FETCH_MISALIGN_CHK_EN to add misalign_o, a pulse on redirects to non-word-aligned targets.
`timescale 1ns/1ps
module inst_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_stop_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_fo,
  output logic [31:0] pc_fo,
  output logic        fetch_valid_o,
  output logic        pipeline_flush_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_pc_f, w_pc_f_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_pend, w_pend_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;
  logic        r_flush;
  logic [31:0] w_jump_tgt;

  assign w_jump_tgt = jump_addr_i & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_pc_f_nxt  = r_pc_f;
    w_valid_nxt = r_valid;
    w_pend_nxt  = r_pend;
    w_tgt_nxt   = r_tgt;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (jump_en_i) begin
          w_pc_nxt    = w_jump_tgt;
          w_valid_nxt = 1'b0;
        end
      end
      S_REQ: begin
        if (ibus_ack_i) begin
          if (jump_en_i) begin
            w_pc_nxt    = w_jump_tgt;
            w_pend_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
          end else if (r_pend) begin
            // data belongs to the path that was redirected away from
            w_pc_nxt    = r_tgt;
            w_pend_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
          end else begin
            w_inst_nxt  = ibus_rdata_i;
            w_pc_f_nxt  = r_pc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = pc_stop_i ? S_HOLD : S_REQ;
          end
        end else begin
          w_valid_nxt = 1'b0;
          // address must stay stable until ack, so the target waits here
          if (jump_en_i) begin
            w_pend_nxt = 1'b1;
            w_tgt_nxt  = w_jump_tgt;
          end
        end
      end
      S_HOLD: begin
        if (jump_en_i) begin
          w_pc_nxt    = w_jump_tgt;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end else if (!pc_stop_i) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_pc    <= 32'h0;
      r_inst  <= 32'h0;
      r_pc_f  <= 32'h0;
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
      r_tgt   <= 32'h0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_pc_f  <= w_pc_f_nxt;
      r_valid <= w_valid_nxt;
      r_pend  <= w_pend_nxt;
      r_tgt   <= w_tgt_nxt;
      r_flush <= jump_en_i;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= jump_en_i && (jump_addr_i[1:0] != 2'b00);
    end
  end

  assign misalign_o = r_misalign;
`endif

  assign ibus_req_o       = (r_state == S_REQ);
  assign ibus_addr_o      = r_pc;
  assign inst_fo          = r_inst;
  assign pc_fo            = r_pc_f;
  assign fetch_valid_o    = r_valid;
  assign pipeline_flush_o = r_flush;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: directed fetch/stall/redirect scenarios, then randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_stop_i = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        ibus_ack_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'h0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic [31:0] inst_fo;
  logic [31:0] pc_fo;
  logic        fetch_valid_o;
  logic        pipeline_flush_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  inst_fetch dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_stop_i        (pc_stop_i),
    .jump_en_i        (jump_en_i),
    .jump_addr_i      (jump_addr_i),
    .ibus_req_o       (ibus_req_o),
    .ibus_addr_o      (ibus_addr_o),
    .ibus_ack_i       (ibus_ack_i),
    .ibus_rdata_i     (ibus_rdata_i),
    .inst_fo          (inst_fo),
    .pc_fo            (pc_fo),
    .fetch_valid_o    (fetch_valid_o),
    .pipeline_flush_o (pipeline_flush_o)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o       (misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        flush;
    logic        mis;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Transaction-level reference: one outstanding fetch at a time, redirects retarget the stream.
  logic        m_start, m_busy, m_drop, m_vld, m_flush, m_mis;
  logic [31:0] m_addr, m_tgt, m_pc, m_inst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_start = 1'b1; m_busy = 1'b0; m_drop = 1'b0; m_vld = 1'b0;
    m_flush = 1'b0; m_mis = 1'b0;
    m_addr = 32'h0; m_tgt = 32'h0; m_pc = 32'h0; m_inst = 32'h0;
  endtask

  task automatic model_step(input logic stop, input logic jump, input logic [31:0] ja,
                            input logic ack, input logic [31:0] rd);
    logic [31:0] al;
    al = {ja[31:2], 2'b00};
    m_flush = jump;
    m_mis   = jump && (ja[1:0] != 2'b00);
    if (m_busy) begin
      if (ack) begin
        if (jump) begin
          m_addr = al; m_drop = 1'b0; m_vld = 1'b0;
        end else if (m_drop) begin
          m_addr = m_tgt; m_drop = 1'b0; m_vld = 1'b0;
        end else begin
          m_inst = rd; m_pc = m_addr; m_vld = 1'b1;
          m_addr = m_addr + 32'd4;
          if (stop) m_busy = 1'b0;
        end
      end else begin
        m_vld = 1'b0;
        if (jump) begin
          m_drop = 1'b1; m_tgt = al;
        end
      end
    end else begin
      if (jump) begin
        m_addr = al; m_vld = 1'b0; m_busy = 1'b1;
      end else if (m_start || !stop) begin
        m_busy = 1'b1;
      end
      m_start = 1'b0;
    end
  endtask

  task automatic cyc(input int rst, input int stop, input int jump, input logic [31:0] ja, input int ack);
    exp_t e;
    @(negedge clk_i);
    rst_i        = (rst != 0);
    pc_stop_i    = (stop != 0);
    jump_en_i    = (jump != 0);
    jump_addr_i  = ja;
    ibus_ack_i   = (ack != 0);
    ibus_rdata_i = $urandom;
    if (!rst_i) begin
      model_reset();
      #1;
      chkb("rst_req", ibus_req_o, 1'b0);
      chk("rst_addr", ibus_addr_o, 32'h0);
      chkb("rst_valid", fetch_valid_o, 1'b0);
      chkb("rst_flush", pipeline_flush_o, 1'b0);
      chk("rst_pc_fo", pc_fo, 32'h0);
      chk("rst_inst_fo", inst_fo, 32'h0);
    end else begin
      model_step(pc_stop_i, jump_en_i, jump_addr_i, ibus_ack_i, ibus_rdata_i);
    end
    e.rst = !rst_i; e.req = m_busy; e.addr = m_addr; e.vld = m_vld;
    e.pc = m_pc; e.inst = m_inst; e.flush = m_flush; e.mis = m_mis;
    expq.push_back(e);
  endtask

  task automatic post();
    @(posedge clk_i);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chkb("sb_req", ibus_req_o, e.req);
        if (e.req || e.rst) chk("sb_addr", ibus_addr_o, e.addr);
        chkb("sb_valid", fetch_valid_o, e.vld);
        if (e.vld || e.rst) begin
          chk("sb_pc_fo", pc_fo, e.pc);
          chk("sb_inst_fo", inst_fo, e.inst);
        end
        chkb("sb_flush", pipeline_flush_o, e.flush);
`ifdef FETCH_MISALIGN_CHK_EN
        chkb("sb_misalign", misalign_o, e.mis);
`endif
      end
    end
  end

  initial begin : stim
    int rst_hold;
    model_reset();
    repeat (3) cyc(0, 0, 0, 0, 0);

    // reset release with a stray ack in the idle cycle, then ack every cycle
    cyc(1, 0, 0, 0, 1); post();
    chkb("s30_req0", ibus_req_o, 1'b1);
    chk("s30_addr0", ibus_addr_o, 32'h0);
    for (int i = 1; i < 3; i++) begin
      cyc(1, 0, 0, 0, 1); post();
      chk("s30_addr", ibus_addr_o, 32'(4 * i));
      chk("s30_pc_fo", pc_fo, 32'(4 * (i - 1)));
      chkb("s30_valid", fetch_valid_o, 1'b1);
    end

    // stall in the ack cycle of 0x8, held three more cycles
    cyc(1, 1, 0, 0, 1); post();
    chk("s31_pc_fo", pc_fo, 32'h8);
    chkb("s31_req", ibus_req_o, 1'b0);
    repeat (3) begin
      cyc(1, 1, 0, 0, 0); post();
      chk("s31_hold_pc_fo", pc_fo, 32'h8);
      chkb("s31_hold_req", ibus_req_o, 1'b0);
      chkb("s31_hold_valid", fetch_valid_o, 1'b1);
    end
    cyc(1, 0, 0, 0, 0); post();
    chkb("s31_resume_req", ibus_req_o, 1'b1);
    chk("s31_resume_addr", ibus_addr_o, 32'hC);

    // redirect to 0x100 while 0x10 is outstanding
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h100, 0); post();
    chk("s32_addr_held", ibus_addr_o, 32'h10);
    chkb("s32_flush", pipeline_flush_o, 1'b1);
    cyc(1, 0, 0, 0, 0); post();
    chk("s32_addr_held2", ibus_addr_o, 32'h10);
    chkb("s32_flush_off", pipeline_flush_o, 1'b0);
    cyc(1, 0, 0, 0, 1); post();
    chk("s32_new_addr", ibus_addr_o, 32'h100);
    chkb("s32_discard", fetch_valid_o, 1'b0);
    cyc(1, 0, 0, 0, 1); post();
    chk("s32_pc_fo", pc_fo, 32'h100);

    // two redirects before a late ack: latest wins
    cyc(1, 0, 1, 32'h200, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h300, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1); post();
    chk("s33_addr", ibus_addr_o, 32'h300);

    // PC wrap from 0xFFFF_FFFC
    cyc(1, 0, 1, 32'hFFFF_FFFC, 1); post();
    chk("s34_addr", ibus_addr_o, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 1); post();
    chk("s34_wrap", ibus_addr_o, 32'h0);
    chk("s34_pc_fo", pc_fo, 32'hFFFF_FFFC);

    // jump beats stall
    cyc(1, 1, 1, 32'h40, 1); post();
    chkb("s23_req", ibus_req_o, 1'b1);
    chk("s23_addr", ibus_addr_o, 32'h40);

    // misaligned redirect target
    cyc(1, 0, 1, 32'h102, 0); post();
    chkb("s35_flush", pipeline_flush_o, 1'b1);
`ifdef FETCH_MISALIGN_CHK_EN
    chkb("s35_misalign", misalign_o, 1'b1);
`endif
    cyc(1, 0, 0, 0, 1); post();
    chk("s35_addr", ibus_addr_o, 32'h100);
`ifdef FETCH_MISALIGN_CHK_EN
    chkb("s35_misalign_off", misalign_o, 1'b0);
`endif

    // reset in the middle of an outstanding request, ack during and right after reset
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1); post();
    chkb("s26_req", ibus_req_o, 1'b1);
    chk("s26_addr", ibus_addr_o, 32'h0);
    chkb("s26_valid", fetch_valid_o, 1'b0);

    rst_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      int r, st, jp, ak;
      logic [31:0] ja;
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 299) == 0) rst_hold = 2;
      r  = (rst_hold > 0) ? 0 : 1;
      st = ($urandom_range(0, 3) == 0) ? 1 : 0;
      jp = ($urandom_range(0, 7) == 0) ? 1 : 0;
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      ak = m_busy ? int'($urandom_range(0, 1)) : (($urandom_range(0, 7) == 0) ? 1 : 0);
      cyc(r, st, jp, ja, ak);
    end

    post();
    post();
    chk("queue_drain", expq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
